// File: rtl/fragment_arbiter.sv
// Merges fragment streams from several render cores into one output stream.
// Round-robin grant with per-core end-of-frame masking and a 1-entry output register.
module fragment_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int DATA_W    = 32,
  localparam int IDW = ($clog2(NUM_CORES) > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [NUM_CORES-1:0]        s_valid,
  input  logic [NUM_CORES-1:0]        s_last,
  input  logic [NUM_CORES*DATA_W-1:0] s_fragment,
  output logic [NUM_CORES-1:0]        s_ready,
  output logic                        m_valid,
  input  logic                        m_ready,
  output logic [DATA_W-1:0]           m_data,
  output logic [IDW-1:0]              m_src,
  output logic                        m_last,
  output logic                        busy,
  output logic                        done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } state_t;

  state_t               state;
  logic [NUM_CORES-1:0] mask;
  logic [NUM_CORES-1:0] mask_nx;
  logic [NUM_CORES-1:0] elig;
  logic [NUM_CORES-1:0] onehot;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       gnt;
  logic [IDW-1:0]       hi;
  logic [IDW-1:0]       lo;
  logic                 hi_found;
  logic                 lo_found;
  logic                 loadable;
  logic                 take;
  logic [DATA_W-1:0]    frag [NUM_CORES];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_frag
    assign frag[i] = s_fragment[i*DATA_W +: DATA_W];
  end

  assign elig     = s_valid & ~mask;
  assign loadable = !m_valid || m_ready;

  // lowest eligible index at/after ptr wins, else lowest overall (wrap)
  always_comb begin
    hi_found = 1'b0;
    hi       = '0;
    lo_found = 1'b0;
    lo       = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_found = 1'b1;
        lo       = IDW'(i);
        if (IDW'(i) >= ptr) begin
          hi_found = 1'b1;
          hi       = IDW'(i);
        end
      end
    end
  end

  assign gnt     = hi_found ? hi : lo;
  assign take    = (state == RUN) && loadable && lo_found;
  assign onehot  = NUM_CORES'(1) << gnt;
  assign s_ready = onehot & {NUM_CORES{take}};
  assign mask_nx = mask | (onehot & {NUM_CORES{s_last[gnt]}});
  assign busy    = (state == RUN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      mask    <= '0;
      ptr     <= '0;
      m_valid <= 1'b0;
      m_data  <= '0;
      m_src   <= '0;
      m_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      if (take) begin
        m_valid <= 1'b1;
        m_data  <= frag[gnt];
        m_src   <= gnt;
        m_last  <= &mask_nx;
        mask    <= mask_nx;
        ptr     <= (gnt == IDW'(NUM_CORES - 1)) ? '0 : gnt + IDW'(1);
      end else if (m_ready) begin
        m_valid <= 1'b0;
        m_last  <= 1'b0;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            done  <= 1'b0;
            mask  <= '0;
            ptr   <= '0;
          end
        end
        RUN: begin
          if (take && (&mask_nx)) state <= FLUSH;
        end
        FLUSH: begin
          if (m_valid && m_ready && m_last) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fragment_arbiter.sv
// Bench for fragment_arbiter: vector table, directed corner cases,
// and random traffic against a frame-level reference model.
module tb_fragment_arbiter;
  localparam int N   = 4;
  localparam int W   = 32;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [N-1:0]   s_valid = '0;
  logic [N-1:0]   s_last = '0;
  logic [N*W-1:0] s_fragment = '0;
  logic [N-1:0]   s_ready;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [W-1:0]   m_data;
  logic [IDW-1:0] m_src;
  logic           m_last;
  logic           busy;
  logic           done;

  fragment_arbiter #(.NUM_CORES(N), .DATA_W(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .s_valid(s_valid), .s_last(s_last), .s_fragment(s_fragment),
    .s_ready(s_ready), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_src(m_src), .m_last(m_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  // reference model: 0 idle, 1 running, 2 draining the final beat
  int         ms;
  bit [N-1:0] finished;
  int         nxt;
  bit         mv;
  bit         ml;
  bit         mdn;
  logic [W-1:0] md;
  int         msrc;

  task automatic mreset();
    ms = 0; finished = '0; nxt = 0;
    mv = 0; ml = 0; mdn = 0; md = '0; msrc = 0;
  endtask

  function automatic int mgrant();
    if (ms != 1 || (mv && !m_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      int c;
      c = (nxt + k) % N;
      if (s_valid[c] && !finished[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    int g;
    logic [N-1:0] er;
    g = mgrant();
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk({tag, " s_ready"}, 64'(s_ready), 64'(er));
    chk({tag, " m_valid"}, 64'(m_valid), 64'(mv));
    chk({tag, " busy"}, 64'(busy), 64'(ms == 1));
    chk({tag, " done"}, 64'(done), 64'(mdn));
    if (mv) begin
      chk({tag, " m_data"}, 64'(m_data), 64'(md));
      chk({tag, " m_src"}, 64'(m_src), 64'(msrc));
      chk({tag, " m_last"}, 64'(m_last), 64'(ml));
    end
  endtask

  task automatic model_edge();
    int g;
    int ms0;
    bit acc;
    g   = mgrant();
    ms0 = ms;
    acc = mv && m_ready;
    if (g >= 0) begin
      finished[g] = finished[g] | s_last[g];
      mv   = 1;
      md   = s_fragment[g*W +: W];
      msrc = g;
      ml   = (finished == '1);
      if (ml) ms = 2;
      nxt  = (g + 1) % N;
    end else if (acc) begin
      if (ms == 2 && ml) begin
        ms  = 0;
        mdn = 1;
      end
      mv = 0;
      ml = 0;
    end
    if (ms0 == 0 && start) begin
      ms = 1; mdn = 0; finished = '0; nxt = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle(string tag);
    @(negedge clk);
    check_all(tag);
    tick();
  endtask

  task automatic do_reset(string tag);
    reset = 1'b1;
    mreset();
    #2;
    chk({tag, " rst m_valid"}, 64'(m_valid), 64'(0));
    chk({tag, " rst done"}, 64'(done), 64'(0));
    chk({tag, " rst busy"}, 64'(busy), 64'(0));
    chk({tag, " rst s_ready"}, 64'(s_ready), 64'(0));
    chk({tag, " rst m_data"}, 64'(m_data), 64'(0));
    chk({tag, " rst m_src"}, 64'(m_src), 64'(0));
    chk({tag, " rst m_last"}, 64'(m_last), 64'(0));
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic tags();
    for (int i = 0; i < N; i++) s_fragment[i*W +: W] = 32'hA000_0000 | i;
  endtask

  typedef struct {
    bit           start;
    logic [N-1:0] v;
    logic [N-1:0] e_rdy;
    bit           e_mv;
    int           e_src;
    bit           e_busy;
  } vec_t;

  vec_t tbl[8];

  initial begin
    mreset();
    tbl[0] = '{1, 4'b0000, 4'b0000, 0, 0, 0};
    tbl[1] = '{0, 4'b1111, 4'b0001, 0, 0, 1};
    tbl[2] = '{0, 4'b1111, 4'b0010, 1, 0, 1};
    tbl[3] = '{0, 4'b1111, 4'b0100, 1, 1, 1};
    tbl[4] = '{0, 4'b1111, 4'b1000, 1, 2, 1};
    tbl[5] = '{0, 4'b1111, 4'b0001, 1, 3, 1};
    tbl[6] = '{0, 4'b1111, 4'b0010, 1, 0, 1};
    tbl[7] = '{0, 4'b0000, 4'b0000, 1, 1, 1};

    do_reset("init");
    tags();

    // full-rate round robin
    for (int i = 0; i < 8; i++) begin
      start   = tbl[i].start;
      s_valid = tbl[i].v;
      @(negedge clk);
      chk("tbl s_ready", 64'(s_ready), 64'(tbl[i].e_rdy));
      chk("tbl m_valid", 64'(m_valid), 64'(tbl[i].e_mv));
      chk("tbl busy", 64'(busy), 64'(tbl[i].e_busy));
      if (tbl[i].e_mv) begin
        chk("tbl m_src", 64'(m_src), 64'(tbl[i].e_src));
        chk("tbl m_data", 64'(m_data), 64'(32'hA000_0000 | tbl[i].e_src));
      end
      check_all("tbl");
      tick();
    end

    // lone core 2, then core 0: pointer lands on 3
    do_reset("c2");
    start = 1; s_valid = '0;
    cycle("c2 start");
    start = 0; s_valid = 4'b0100;
    s_fragment[2*W +: W] = 32'hDEADBEEF;
    cycle("c2 load");
    s_valid = 4'b0001;
    @(negedge clk);
    chk("c2 m_data", 64'(m_data), 64'(32'hDEADBEEF));
    chk("c2 m_src", 64'(m_src), 64'(2));
    chk("c2 grant0", 64'(s_ready), 64'(4'b0001));
    check_all("c2");
    tick();
    tags();

    // stall with full output register
    s_valid = 4'b1111; m_ready = 1;
    cycle("stall load");
    m_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall s_ready", 64'(s_ready), 64'(0));
      chk("stall m_data", 64'(m_data), 64'(32'hA000_0001));
      chk("stall m_valid", 64'(m_valid), 64'(1));
      check_all("stall");
      tick();
    end
    m_ready = 1;
    @(negedge clk);
    chk("resume grant", 64'(s_ready), 64'(4'b0100));
    check_all("resume");
    tick();
    cycle("resume2");

    // last beats in order 1,3,0,2
    do_reset("lastseq");
    start = 1; s_valid = '0;
    cycle("ls start");
    start = 0;
    s_valid = 4'b0010; s_last = 4'b0010; cycle("ls c1");
    s_valid = 4'b1000; s_last = 4'b1000; cycle("ls c3");
    s_valid = 4'b0001; s_last = 4'b0001; cycle("ls c0");
    s_valid = 4'b0100; s_last = 4'b0100; cycle("ls c2");
    s_valid = 4'b1111; s_last = 4'b0000;
    @(negedge clk);
    chk("ls m_last", 64'(m_last), 64'(1));
    chk("ls m_src", 64'(m_src), 64'(2));
    chk("ls busy", 64'(busy), 64'(0));
    check_all("ls flush");
    tick();
    @(negedge clk);
    chk("ls done", 64'(done), 64'(1));
    chk("ls idle rdy", 64'(s_ready), 64'(0));
    check_all("ls idle");
    tick();

    // finished core keeps s_valid high
    do_reset("mask");
    start = 1; s_valid = '0;
    cycle("mk start");
    start = 0; s_valid = 4'b0010; s_last = 4'b0010;
    cycle("mk c1");
    s_valid = 4'b1111; s_last = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("mask rdy1", 64'(s_ready[1]), 64'(0));
      check_all("mask");
      tick();
    end
    s_valid = 4'b0010;
    cycle("mask alone");
    cycle("mask alone");
    s_last = '0;

    // reset with a beat buffered, then restart from pointer 0
    s_valid = 4'b1111;
    cycle("mr fill");
    do_reset("midrst");
    start = 1; s_valid = '0;
    cycle("mr start");
    start = 0; s_valid = 4'b1111;
    @(negedge clk);
    chk("mr grant0", 64'(s_ready), 64'(4'b0001));
    check_all("mr");
    tick();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 599) == 0) do_reset("rnd");
      start   = ($urandom_range(0, 7) == 0);
      s_valid = N'($urandom);
      s_last  = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
      m_ready = ($urandom_range(0, 3) != 0);
      for (int c = 0; c < N; c++) s_fragment[c*W +: W] = $urandom;
      cycle("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
